// File: rtl/mux4x1_rr_arbiter_pkg.sv
// Shared types and defaults for the 4-lane round-robin datapath arbiter.
// State encodings and a one-hot to index helper.
package mux4x1_rr_arbiter_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF     = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_SERVE = 1'b1
  } arb_state_t;

  function automatic logic [1:0] enc4(
    input logic [3:0] oh
  );
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      oh[1]:   r = 2'd1;
      oh[2]:   r = 2'd2;
      oh[3]:   r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux4x1_rr_arbiter_if.sv
// Lane-side and downstream-side signals of the arbiter.
// master = arbiter, slave = sources plus downstream.
interface mux4x1_rr_arbiter_if
  import mux4x1_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [3:0]        valid;
  logic              ready;
  logic [3:0]        pop;
  logic [3:0]        grant;
  logic [DATA_W-1:0] out;
  logic              valid_out;
  logic              busy;

  modport master (
    input  in0, in1, in2, in3,
    input  valid, ready,
    output pop, grant, out,
    output valid_out, busy
  );

  modport slave (
    output in0, in1, in2, in3,
    output valid, ready,
    input  pop, grant, out,
    input  valid_out, busy
  );

endinterface

// File: rtl/mux4x1_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick of one of four requesters.
// The lane after 'last' has highest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] gnt_onehot,
  output logic       any
);

  logic [1:0] base;
  logic [1:0] k;
  logic [3:0] rot;
  logic [1:0] idx;
  logic [1:0] pos;

  always_comb begin
    base = last + 2'd1;
    rot  = '0;
    k    = '0;
    for (int i = 0; i < 4; i++) begin
      k      = 2'(i) + base;
      rot[i] = req[k];
    end

    if (rot[0])      idx = 2'd0;
    else if (rot[1]) idx = 2'd1;
    else if (rot[2]) idx = 2'd2;
    else             idx = 2'd3;

    any        = |req;
    pos        = idx + base;
    gnt_onehot = '0;
    gnt_onehot[pos] = any;
  end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin burst scheduler sharing one datapath among four lanes.
// Two-state FSM, burst counter, last-served pointer, registered output.
module mux4x1_rr_arbiter
  import mux4x1_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mux4x1_rr_arbiter_if.master  bus
);

  arb_state_t        state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vout_q, vout_d;

  logic [3:0]        pick;
  logic              any;
  logic [3:0]        pop;
  logic              popped;
  logic              drained;
  logic              burst_end;
  logic [DATA_W-1:0] sel;

  rr_pick4 u_pick (
    .req        (bus.valid),
    .last       (last_q),
    .gnt_onehot (pick),
    .any        (any)
  );

  assign pop = (state_q == ARB_SERVE)
             ? (grant_q & bus.valid & {4{bus.ready}})
             : 4'b0000;

  assign popped    = |pop;
  assign drained   = ~|(grant_q & bus.valid);
  assign burst_end = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    sel = '0;
    unique case (1'b1)
      grant_q[0]: sel = bus.in0;
      grant_q[1]: sel = bus.in1;
      grant_q[2]: sel = bus.in2;
      grant_q[3]: sel = bus.in3;
      default:    sel = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    out_d   = out_q;
    vout_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        if (popped) begin
          out_d  = sel;
          vout_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
        // a drained lane is released even when ready is high
        if (drained || (popped && burst_end)) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          last_d  = enc4(grant_q);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      out_q   <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      out_q   <= out_d;
      vout_q  <= vout_d;
    end
  end

  assign bus.pop       = pop;
  assign bus.grant     = grant_q;
  assign bus.out       = out_q;
  assign bus.valid_out = vout_q;
  assign bus.busy      = (state_q == ARB_SERVE);

endmodule
